// File: rtl/gnrc_addr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_addr_pkg
// Description : Shared types and helpers for the generic address map blocks.
//               Holds the region-bound rules (NAPOT / TOR) so the decoder and
//               the burst generator elaborate identical regions from one MAP.
// Revision    : 1.0 - initial release
// ============================================================================
package gnrc_addr_pkg;

    // Widest address the elaboration-time helpers handle.
    localparam int MAX_AW = 64;

    // One spare bit above the widest address so carries stay visible.
    typedef logic [MAX_AW:0]   addr_ext_t;
    typedef logic [MAX_AW-1:0] map_word_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } burst_state_e;

    // Lowest set bit of vec within the low 'width' bits; 'width' if none set.
    function automatic int find_first_one(input map_word_t vec, input int width);
        find_first_one = width;
        for (int i = MAX_AW - 1; i >= 0; i--) begin
            if ((i < width) && vec[i]) begin
                find_first_one = i;
            end
        end
    endfunction

    // 2^aw - 1 in the extended width.
    function automatic addr_ext_t width_mask(input int aw);
        width_mask = (addr_ext_t'(1) << aw) - addr_ext_t'(1);
    endfunction

    // First address of region k.
    function automatic addr_ext_t region_base(input map_word_t map_cur,
                                              input map_word_t map_prev,
                                              input int        k,
                                              input bit        napot,
                                              input int        aw);
        addr_ext_t m;
        int        w;
        m = addr_ext_t'(map_cur) & width_mask(aw);
        if (napot) begin
            // The first zero marks the size; everything at and below it is offset.
            w = find_first_one(~map_cur, aw);
            if (w >= aw) begin
                region_base = '0;
            end else begin
                region_base = m & ~((addr_ext_t'(1) << (w + 1)) - addr_ext_t'(1));
            end
        end else if (k == 0) begin
            region_base = '0;
        end else begin
            region_base = addr_ext_t'(map_prev) & width_mask(aw);
        end
    endfunction

    // Last (inclusive) address of region k.
    function automatic addr_ext_t region_last(input map_word_t map_cur,
                                              input int        k,
                                              input int        nr,
                                              input bit        napot,
                                              input int        aw);
        addr_ext_t m;
        int        w;
        m = addr_ext_t'(map_cur) & width_mask(aw);
        if (napot) begin
            w = find_first_one(~map_cur, aw);
            if (w >= aw) begin
                region_last = width_mask(aw);
            end else begin
                region_last = m | (addr_ext_t'(1) << w);
            end
        end else if (k >= nr) begin
            region_last = width_mask(aw);
        end else if (m == '0) begin
            region_last = '0;
        end else begin
            region_last = m - addr_ext_t'(1);
        end
    endfunction

    // Index is addressable and its TOR region is non-empty.
    function automatic bit region_valid(input map_word_t map_cur,
                                        input map_word_t map_prev,
                                        input int        k,
                                        input int        nr,
                                        input bit        napot,
                                        input int        aw);
        if (napot) begin
            return k < nr;
        end
        if (k > nr) begin
            return 1'b0;
        end
        if ((k < nr) && ((addr_ext_t'(map_cur) & width_mask(aw)) == '0)) begin
            return 1'b0;
        end
        return region_base(map_cur, map_prev, k, napot, aw)
               <= region_last(map_cur, k, nr, napot, aw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gnrc_addr_region_lut.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_addr_region_lut
// Description : Combinational region table. Maps a region index to its base,
//               inclusive last address and a valid flag; all entries are
//               elaborated as constants from MAP / NAPOT.
// Revision    : 1.0 - initial release
// ============================================================================
module gnrc_addr_region_lut
    import gnrc_addr_pkg::*;
#(
    parameter int                     AW    = 32,
    parameter int                     NR    = 1,
    parameter int                     NAPOT = 1,
    parameter logic [NR-1:0][AW-1:0]  MAP   = '0,
    parameter int                     CW    = 1
) (
    input  logic [CW-1:0] i_idx,
    output logic [AW:0]   o_base,
    output logic [AW:0]   o_last,
    output logic          o_idx_valid
);

    // TOR has one extra region above the last rule.
    localparam int NE = NR + ((NAPOT == 0) ? 1 : 0);

    // MAP entry k zero-extended; out-of-range k reads as zero.
    function automatic map_word_t map_at(input int k);
        map_at = '0;
        for (int j = 0; j < NR; j++) begin
            if (j == k) begin
                map_at = map_word_t'(MAP[j]);
            end
        end
    endfunction

    logic [AW:0] w_base_tab [NE];
    logic [AW:0] w_last_tab [NE];
    logic        w_ok_tab   [NE];

    for (genvar k = 0; k < NE; k++) begin : g_region
        localparam addr_ext_t c_base = region_base(map_at(k), map_at(k - 1), k, NAPOT != 0, AW);
        localparam addr_ext_t c_last = region_last(map_at(k), k, NR, NAPOT != 0, AW);
        localparam bit        c_ok   = region_valid(map_at(k), map_at(k - 1), k, NR, NAPOT != 0, AW);
        assign w_base_tab[k] = c_base[AW:0];
        assign w_last_tab[k] = c_last[AW:0];
        assign w_ok_tab[k]   = c_ok;
    end

    // Select the entry for i_idx; indices past the table read as invalid.
    always_comb begin
        o_base      = '0;
        o_last      = '0;
        o_idx_valid = 1'b0;
        for (int k = 0; k < NE; k++) begin
            if (i_idx == CW'(k)) begin
                o_base      = w_base_tab[k];
                o_last      = w_last_tab[k];
                o_idx_valid = w_ok_tab[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gnrc_addr_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : gnrc_addr_burst_gen
// Description : Turns (region, offset, len, wrap) commands into a valid/ready
//               stream of absolute addresses inside the selected region, with
//               optional wrap to the region base and an error beat for
//               illegal indices or out-of-region accesses. AW <= 64.
// Revision    : 1.0 - initial release
// ============================================================================
module gnrc_addr_burst_gen
    import gnrc_addr_pkg::*;
#(
    parameter int                     AW    = 32,
    parameter int                     NR    = 1,
    parameter int                     NAPOT = 1,
    parameter logic [NR-1:0][AW-1:0]  MAP   = '0,
    parameter int                     LW    = 8,
    localparam int                    CW    = ((NR + ((NAPOT == 0) ? 1 : 0)) > 1) ?
                                              $clog2(NR + ((NAPOT == 0) ? 1 : 0)) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic [CW-1:0] req_idx_i,
    input  logic [AW-1:0] req_offset_i,
    input  logic [LW-1:0] req_len_i,
    input  logic          req_wrap_i,
    output logic          addr_valid_o,
    input  logic          addr_ready_i,
    output logic [AW-1:0] addr_o,
    output logic          addr_last_o,
    output logic          addr_err_o
);

    burst_state_e state_q, state_d;
    logic [AW:0]   addr_q, addr_d;
    logic [LW-1:0] rem_q, rem_d;
    logic [AW:0]   base_q, base_d;
    logic [AW:0]   last_q, last_d;
    logic          wrap_q, wrap_d;
    logic          valid_q, valid_d;
    logic          last_beat_q, last_beat_d;
    logic          err_q, err_d;

    logic [AW:0]   w_lut_base;
    logic [AW:0]   w_lut_last;
    logic          w_lut_ok;
    logic [AW:0]   w_start;
    logic [AW:0]   w_next;
    logic          w_hs;

    gnrc_addr_region_lut #(
        .AW    (AW),
        .NR    (NR),
        .NAPOT (NAPOT),
        .MAP   (MAP),
        .CW    (CW)
    ) u_region_lut (
        .i_idx       (req_idx_i),
        .o_base      (w_lut_base),
        .o_last      (w_lut_last),
        .o_idx_valid (w_lut_ok)
    );

    // Extended-width sums: base + offset and addr + 1 can exceed 2^AW-1 visibly.
    assign w_start = w_lut_base + {1'b0, req_offset_i};
    assign w_next  = addr_q + (AW + 1)'(1);
    assign w_hs    = valid_q & addr_ready_i;

    assign req_ready_o  = (state_q == ST_IDLE);
    assign addr_valid_o = valid_q;
    assign addr_o       = addr_q[AW-1:0];
    assign addr_last_o  = last_beat_q;
    assign addr_err_o   = err_q;

    // Next-state logic: command accept, beat advance with wrap/truncate, retire.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        base_d      = base_q;
        last_d      = last_q;
        wrap_d      = wrap_q;
        valid_d     = valid_q;
        last_beat_d = last_beat_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    valid_d = 1'b1;
                    if (!w_lut_ok || (w_start > w_lut_last)) begin
                        state_d     = ST_ERR;
                        addr_d      = '0;
                        rem_d       = '0;
                        last_beat_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        state_d     = ST_BURST;
                        addr_d      = w_start;
                        rem_d       = req_len_i;
                        last_beat_d = (req_len_i == '0);
                        err_d       = 1'b0;
                        base_d      = w_lut_base;
                        last_d      = w_lut_last;
                        wrap_d      = req_wrap_i;
                    end
                end
            end
            ST_BURST: begin
                if (w_hs) begin
                    if (rem_q == '0) begin
                        state_d     = ST_IDLE;
                        valid_d     = 1'b0;
                        last_beat_d = 1'b0;
                    end else if ((w_next > last_q) && !wrap_q) begin
                        // Ran off the region end: replace the rest with one error beat.
                        state_d     = ST_ERR;
                        addr_d      = '0;
                        rem_d       = '0;
                        last_beat_d = 1'b1;
                        err_d       = 1'b1;
                    end else begin
                        addr_d      = (w_next > last_q) ? base_q : w_next;
                        rem_d       = rem_q - LW'(1);
                        last_beat_d = (rem_q == LW'(1));
                    end
                end
            end
            ST_ERR: begin
                if (w_hs) begin
                    state_d     = ST_IDLE;
                    valid_d     = 1'b0;
                    last_beat_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                valid_d     = 1'b0;
                last_beat_d = 1'b0;
                err_d       = 1'b0;
            end
        endcase
    end

    // State and registered outputs; async reset drops valid immediately.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            base_q      <= '0;
            last_q      <= '0;
            wrap_q      <= 1'b0;
            valid_q     <= 1'b0;
            last_beat_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            base_q      <= base_d;
            last_q      <= last_d;
            wrap_q      <= wrap_d;
            valid_q     <= valid_d;
            last_beat_q <= last_beat_d;
            err_q       <= err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gnrc_addr_burst_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_gnrc_addr_burst_gen
// Description : Self-checking bench for gnrc_addr_burst_gen. Two instances
//               (NAPOT and TOR maps) share stimulus; expected beats come from
//               a region/burst model built from the address-map rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gnrc_addr_burst_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid_a = 1'b0;
    logic       req_valid_b = 1'b0;
    logic [1:0] req_idx = '0;
    logic [7:0] req_offset = '0;
    logic [7:0] req_len = '0;
    logic       req_wrap = 1'b0;
    logic       addr_ready = 1'b1;

    logic       req_ready_a, addr_valid_a, addr_last_a, addr_err_a;
    logic [7:0] addr_a;
    logic       req_ready_b, addr_valid_b, addr_last_b, addr_err_b;
    logic [7:0] addr_b;

    int n_checks = 0;
    int n_pass   = 0;

    // Rule tables as seen by the model (index 0 first).
    int map_napot [2] = '{63, 159};
    int map_tor   [2] = '{100, 200};

    int exp_addr [$];
    bit exp_last [$];
    bit exp_err  [$];

    always #5 clk = ~clk;

    gnrc_addr_burst_gen #(
        .AW(8), .NR(2), .NAPOT(1), .MAP({8'd159, 8'd63}), .LW(8)
    ) u_dut_napot (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid_a),
        .req_ready_o  (req_ready_a),
        .req_idx_i    (req_idx[0:0]),
        .req_offset_i (req_offset),
        .req_len_i    (req_len),
        .req_wrap_i   (req_wrap),
        .addr_valid_o (addr_valid_a),
        .addr_ready_i (addr_ready),
        .addr_o       (addr_a),
        .addr_last_o  (addr_last_a),
        .addr_err_o   (addr_err_a)
    );

    gnrc_addr_burst_gen #(
        .AW(8), .NR(2), .NAPOT(0), .MAP({8'd200, 8'd100}), .LW(8)
    ) u_dut_tor (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid_b),
        .req_ready_o  (req_ready_b),
        .req_idx_i    (req_idx),
        .req_offset_i (req_offset),
        .req_len_i    (req_len),
        .req_wrap_i   (req_wrap),
        .addr_valid_o (addr_valid_b),
        .addr_ready_i (addr_ready),
        .addr_o       (addr_b),
        .addr_last_o  (addr_last_b),
        .addr_err_o   (addr_err_b)
    );

    // Expected beat list for one command, from the region rules.
    function automatic void build_model(input bit tor, input int idx, input int off,
                                        input int len, input bit wrap);
        bit ok;
        int base, last, a, m, w;
        exp_addr.delete(); exp_last.delete(); exp_err.delete();
        ok = 1'b1; base = 0; last = 0;
        if (!tor) begin
            if (idx > 1) ok = 1'b0;
            else begin
                m = map_napot[idx];
                w = 0;
                while (w < 8 && m[w]) w++;
                base = (m >> (w + 1)) << (w + 1);
                last = m | (1 << w);
            end
        end else begin
            if (idx > 2) ok = 1'b0;
            else begin
                if (idx == 0) base = 0; else base = map_tor[idx - 1];
                if (idx == 2) last = 255; else last = map_tor[idx] - 1;
            end
        end
        if (!ok || (base + off > last)) begin
            exp_addr.push_back(0); exp_last.push_back(1'b1); exp_err.push_back(1'b1);
        end else begin
            a = base + off;
            for (int i = 0; i <= len; i++) begin
                if (a > last) begin
                    if (wrap) a = base;
                    else begin
                        exp_addr.push_back(0); exp_last.push_back(1'b1); exp_err.push_back(1'b1);
                        break;
                    end
                end
                exp_addr.push_back(a); exp_last.push_back(i == len); exp_err.push_back(1'b0);
                a++;
            end
        end
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid_a = 1'b0; req_valid_b = 1'b0; addr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // mode: 0 = always ready, 1 = random ready, 2 = 3-cycle stall at beat 2.
    task automatic run_cmd(input bit tor, input int idx, input int off, input int len,
                           input bit wrap, input int mode, input string tag);
        int   cyc, beat, stall;
        bit   rdy, broken;
        logic ov, ol, oe, orr;
        logic [7:0] oa;
        build_model(tor, idx, off, len, wrap);
        @(negedge clk);
        req_idx = 2'(idx); req_offset = 8'(off); req_len = 8'(len); req_wrap = wrap;
        if (tor) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        addr_ready = 1'b1;
        orr = tor ? req_ready_b : req_ready_a;
        n_checks++;
        if (orr !== 1'b1) $display("FAIL %s accept_ready: got %b want 1", tag, orr);
        else n_pass++;
        @(posedge clk); #1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        // Scramble the command fields: the DUT must use its captured copy.
        req_idx = 2'($urandom); req_offset = 8'($urandom); req_len = 8'($urandom);
        req_wrap = 1'($urandom);
        cyc = 0; beat = 0; stall = 0; broken = 1'b0;
        while (exp_addr.size() > 0 && !broken) begin
            @(negedge clk);
            cyc++;
            ov = tor ? addr_valid_b : addr_valid_a;
            oa = tor ? addr_b : addr_a;
            ol = tor ? addr_last_b : addr_last_a;
            oe = tor ? addr_err_b : addr_err_a;
            n_checks++;
            if (ov !== 1'b1) begin
                $display("FAIL %s valid beat%0d cyc%0d: got %b want 1", tag, beat, cyc, ov);
                broken = 1'b1;
            end else begin
                n_pass++;
                n_checks++;
                if (oa !== 8'(exp_addr[0]) || ol !== exp_last[0] || oe !== exp_err[0])
                    $display("FAIL %s beat%0d: got addr=%0d last=%b err=%b want addr=%0d last=%b err=%b",
                             tag, beat, oa, ol, oe, exp_addr[0], exp_last[0], exp_err[0]);
                else n_pass++;
                rdy = 1'b1;
                if (mode == 1) rdy = 1'($urandom);
                else if (mode == 2 && beat == 2 && stall < 3) rdy = 1'b0;
                if (!rdy) stall++;
                addr_ready = rdy;
                if (rdy) begin
                    void'(exp_addr.pop_front()); void'(exp_last.pop_front());
                    void'(exp_err.pop_front());
                    beat++;
                end
                if (cyc > 400) begin
                    n_checks++;
                    $display("FAIL %s timeout: got %0d beats left want 0", tag, exp_addr.size());
                    broken = 1'b1;
                end
            end
        end
        if (broken) begin
            apply_reset();
        end else begin
            @(negedge clk);
            addr_ready = 1'b1;
            ov  = tor ? addr_valid_b : addr_valid_a;
            orr = tor ? req_ready_b : req_ready_a;
            n_checks++;
            if (ov !== 1'b0 || orr !== 1'b1)
                $display("FAIL %s retire: got valid=%b ready=%b want valid=0 ready=1", tag, ov, orr);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({addr_valid_a, addr_last_a, addr_err_a, addr_a, addr_valid_b, addr_last_b, addr_err_b, addr_b} !== '0)
            $display("FAIL reset_outputs: got a=%b%b%b/%0d b=%b%b%b/%0d want all 0",
                     addr_valid_a, addr_last_a, addr_err_a, addr_a, addr_valid_b, addr_last_b, addr_err_b, addr_b);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready_a !== 1'b1 || req_ready_b !== 1'b1 || addr_valid_a !== 1'b0 || addr_valid_b !== 1'b0)
            $display("FAIL reset_idle: got ready=%b%b valid=%b%b want ready=11 valid=00",
                     req_ready_a, req_ready_b, addr_valid_a, addr_valid_b);
        else n_pass++;
    endtask

    task automatic test_napot_contig();
        run_cmd(1'b0, 1, 4, 3, 1'b0, 0, "napot_contig");
    endtask

    task automatic test_napot_wrap();
        run_cmd(1'b0, 1, 62, 3, 1'b1, 0, "napot_wrap");
        run_cmd(1'b0, 1, 10, 150, 1'b1, 0, "napot_multi_wrap");
    endtask

    task automatic test_napot_truncate();
        run_cmd(1'b0, 1, 62, 3, 1'b0, 0, "napot_truncate");
    endtask

    task automatic test_invalid();
        run_cmd(1'b1, 3, 0, 5, 1'b0, 0, "tor_bad_idx");
        run_cmd(1'b0, 1, 64, 2, 1'b0, 0, "napot_off_oob");
        run_cmd(1'b1, 2, 56, 0, 1'b1, 0, "tor_off_oob");
    endtask

    task automatic test_tor();
        run_cmd(1'b1, 2, 54, 2, 1'b1, 0, "tor_top_wrap");
        run_cmd(1'b1, 0, 99, 1, 1'b1, 0, "tor_low_wrap");
        run_cmd(1'b1, 1, 0, 0, 1'b0, 0, "tor_single");
    endtask

    task automatic test_backpressure();
        run_cmd(1'b0, 0, 10, 5, 1'b0, 2, "bp_stall");
        run_cmd(1'b1, 1, 30, 8, 1'b1, 1, "bp_random");
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        req_idx = 2'd0; req_offset = 8'd0; req_len = 8'd50; req_wrap = 1'b0;
        req_valid_a = 1'b1; addr_ready = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (addr_valid_a !== 1'b1) $display("FAIL rst_mid_pre: got valid=%b want 1", addr_valid_a);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (addr_valid_a !== 1'b0 || addr_a !== 8'd0 || addr_last_a !== 1'b0)
            $display("FAIL rst_mid_async: got valid=%b addr=%0d last=%b want 0/0/0",
                     addr_valid_a, addr_a, addr_last_a);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (req_ready_a !== 1'b1 || addr_valid_a !== 1'b0)
            $display("FAIL rst_mid_idle: got ready=%b valid=%b want 1/0", req_ready_a, addr_valid_a);
        else n_pass++;
        run_cmd(1'b0, 0, 120, 2, 1'b0, 0, "rst_mid_after");
    endtask

    task automatic test_random();
        bit tor;
        for (int n = 0; n < 40; n++) begin
            tor = 1'($urandom);
            if (tor)
                run_cmd(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 120)),
                        int'($urandom_range(0, 12)), 1'($urandom), 1, "rand_tor");
            else
                run_cmd(1'b0, int'($urandom_range(0, 1)), int'($urandom_range(0, 140)),
                        int'($urandom_range(0, 12)), 1'($urandom), 1, "rand_napot");
        end
    endtask

    initial begin
        test_reset();
        test_napot_contig();
        test_napot_wrap();
        test_napot_truncate();
        test_invalid();
        test_tor();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
